// File: rtl/uart8_receiver_os.sv
`default_nettype none
// ============================================================================
// Module   : uart8_receiver_os
// Brief    : 8N1 UART receiver on an OVERSAMPLE x baud clock; centre-sampled
//            bits, one-cycle done strobe and framing-error flag.
// Revision : 1.0  initial release
// ============================================================================
module uart8_receiver_os #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in,
    output logic [7:0] out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int                  c_tick_w    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_tick_w-1:0] c_tick_half = c_tick_w'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_BREAK = 3'd5
    } state_t;

    state_t                   r_state;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_rx_prev;
    logic [c_tick_w-1:0]      r_tick;
    logic [2:0]               r_bit;
    logic [7:0]               r_shift;
    logic [7:0]               r_out;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;
    logic                     w_rx_s;

    assign w_rx_s = r_sync[SYNC_STAGES-1];
    assign out    = r_out;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
            r_state   <= ST_RESET;
            r_tick    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_out     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], in};
            r_rx_prev <= w_rx_s;
            r_done    <= 1'b0;
            if (!en) begin
                // Partial frame is dropped; out and err keep their last values.
                r_state <= ST_RESET;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_RESET: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (!w_rx_s && r_rx_prev) begin
                            r_tick  <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (r_tick == c_tick_half) begin
                            r_tick <= '0;
                            if (!w_rx_s) begin
                                r_err   <= 1'b0;
                                r_bit   <= '0;
                                r_state <= ST_DATA;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (r_tick == c_tick_last) begin
                            r_tick  <= '0;
                            r_shift <= {w_rx_s, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (r_tick == c_tick_last) begin
                            r_tick <= '0;
                            r_out  <= r_shift;
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
                            if (w_rx_s) begin
                                r_err   <= 1'b0;
                                r_state <= ST_IDLE;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= ST_BREAK;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        // Hold off start detection until the line has returned high.
                        if (w_rx_s) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_RESET;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart8_receiver_os.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart8_receiver_os
// Brief    : Directed frames into uart8_receiver_os with a queue scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart8_receiver_os;

    localparam int c_os = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       rx;
    logic [7:0] out;
    logic       busy;
    logic       done;
    logic       err;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [8:0] exp_q[$];
    int         done_cyc[$];
    int         busy_rise = -1;
    int         busy_fall = -1;
    logic       busy_prev = 1'b0;

    uart8_receiver_os #(.OVERSAMPLE(c_os), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in    (rx),
        .out   (out),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_cyc(c_os);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic exp_err);
        exp_q.push_back({exp_err, d});
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    // Monitor: pops the scoreboard whenever done is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && !busy_prev) busy_rise = cyc;
            if (!busy && busy_prev) busy_fall = cyc;
            if (done) begin
                logic [8:0] e;
                done_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got out=%0h err=%0b, expected no frame", out, err);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_out", {24'd0, out}, {24'd0, e[7:0]});
                    check("frame_err", {31'd0, err}, {31'd0, e[8]});
                end
            end
        end
        busy_prev = busy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int g0;
        int f0;
        int last;
        rst_n = 1'b0;
        en    = 1'b1;
        rx    = 1'b1;
        wait_cyc(3);
        check("rst_out",  {24'd0, out}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err",  {31'd0, err},  32'd0);
        rst_n = 1'b1;
        wait_cyc(4);

        // Frame 0xA5: done 153 cycles after rx_s goes low (2 sync cycles after the pin).
        e0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_cyc(16);
        check("a5_done_count", done_cyc.size(), 32'd1);
        last = (done_cyc.size() > 0) ? done_cyc[done_cyc.size()-1] : -1;
        check("a5_done_cycle", last, e0 + 2 + 153);
        check("a5_busy_fall", busy_fall, e0 + 2 + 153);
        checks++;
        if (!(busy_rise == e0 + 2 || busy_rise == e0 + 3)) begin
            errors++;
            $display("FAIL a5_busy_rise: got %0d, expected %0d or %0d", busy_rise, e0 + 2, e0 + 3);
        end

        // 3-cycle glitch: start aborts at mid-bit, no done.
        g0 = cyc;
        rx = 1'b0;
        wait_cyc(3);
        rx = 1'b1;
        wait_cyc(30);
        check("glitch_busy_seen", {31'd0, (busy_rise > g0)}, 32'd1);
        check("glitch_busy_back", {31'd0, (busy_fall > busy_rise)}, 32'd1);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_out", {24'd0, out}, 32'hA5);
        check("glitch_err", {31'd0, err}, 32'd0);

        // 0x3C with low stop bit, line held low for 20 bit times in total.
        send_frame(8'h3C, 1'b0, 1'b1);
        rx = 1'b0;
        wait_cyc(19 * c_os);
        check("break_err", {31'd0, err}, 32'd1);
        check("break_busy", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        wait_cyc(48);
        check("break_err_hold", {31'd0, err}, 32'd1);
        check("break_done_count", done_cyc.size(), 32'd2);

        // Back-to-back frames, one stop bit each.
        f0 = done_cyc.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        wait_cyc(16);
        check("b2b_count", done_cyc.size(), f0 + 3);
        if (done_cyc.size() >= f0 + 3) begin
            check("b2b_gap1", done_cyc[f0+1] - done_cyc[f0], 32'd160);
            check("b2b_gap2", done_cyc[f0+2] - done_cyc[f0+1], 32'd160);
        end
        check("b2b_last_out", {24'd0, out}, 32'h55);

        // 0x81 interrupted by reset in data bit 4.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b0;
        wait_cyc(8);
        rst_n = 1'b0;
        #1;
        check("midrst_out",  {24'd0, out}, 32'h00);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_err",  {31'd0, err},  32'd0);
        wait_cyc(8 + 3 * c_os);
        rx = 1'b1;
        wait_cyc(32);
        rst_n = 1'b1;
        wait_cyc(4);
        check("postrst_out", {24'd0, out}, 32'h00);
        send_frame(8'h42, 1'b1, 1'b0);
        wait_cyc(16);
        check("rst_then_42", {24'd0, out}, 32'h42);

        // 0x99 aborted by en low inside data bit 6 (a low bit, so no edge follows).
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b0;
        wait_cyc(4);
        en = 1'b0;
        wait_cyc(5);
        en = 1'b1;
        wait_cyc(7);
        send_bit(1'b1);
        send_bit(1'b1);
        wait_cyc(32);
        check("en_abort_busy", {31'd0, busy}, 32'd0);
        check("en_abort_out", {24'd0, out}, 32'h42);
        send_frame(8'h7E, 1'b1, 1'b0);
        wait_cyc(16);
        check("en_then_7e", {24'd0, out}, 32'h7E);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_cyc(1);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("total_done", done_cyc.size(), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart8_receiver_os.md
Name: uart8_receiver_os

Overview:
- 8-bit UART receiver, 8N1 framing, consuming the serial tx line produced by the 8-bit transmitter.
- Runs on an oversampling clock: clk = OVERSAMPLE x baud, derived from the system clock upstream.
- Detects the start bit, samples each bit at its centre, and presents the received byte with a one-cycle done strobe and a framing-error flag.
- Sits at the chip's rx pin, in front of any byte sink or FIFO.

Parameters:
- OVERSAMPLE, 16, clk cycles per bit; even, >= 4.
- SYNC_STAGES, 2, flops in the rx-line synchronizer; >= 2.

Ports:
- clk  input  1  oversampling clock, OVERSAMPLE x baud.
- rst_n  input  1  asynchronous reset, active low.
- en  input  1  receiver enable; low forces idle.
- in  input  1  raw serial rx line, asynchronous.
- out  output  8  last received byte; held until the next valid frame.
- busy  output  1  frame reception in progress.
- done  output  1  one-cycle strobe: frame complete (valid or errored).
- err  output  1  framing error (stop bit sampled low) on the last frame.

Behaviour:
- Reset (rst_n low, async):
  - Synchronizer flops = 1, state = RESET, counters = 0, shift reg = 0.
  - out = 8'h00, busy = 0, done = 0, err = 0.
- Synchronizer: `in` passes through SYNC_STAGES flops to give rx_s; all FSM logic uses rx_s only.
- Counters: tick counter, width clog2(OVERSAMPLE); bit counter, 3 bits, wraps 7->0.
- States and transitions:
  - RESET: busy = 0, done = 0. Go to IDLE when en = 1.
  - IDLE: done = 0. On rx_s = 0 (falling edge; previous rx_s = 1), clear tick counter and go to START_BIT.
  - START_BIT: busy = 1. Count OVERSAMPLE/2 cycles, then sample rx_s.
    - rx_s = 0: clear err, clear tick counter, go to DATA_BITS.
    - rx_s = 1: false start (glitch). Go to IDLE, busy = 0; no done, err unchanged.
  - DATA_BITS: sample rx_s every OVERSAMPLE cycles.
    - Shift right, new bit into [7], so the byte is received LSB first.
    - Increment bit counter; after the 8th sample (counter wraps), go to STOP_BIT.
  - STOP_BIT: after OVERSAMPLE cycles, sample rx_s.
    - Always: out <= shift reg, done <= 1, busy <= 0.
    - rx_s = 1: err <= 0, go to IDLE.
    - rx_s = 0: err <= 1, go to BREAK_WAIT.
  - BREAK_WAIT: done = 0. Stay until rx_s = 1, then go to IDLE. This prevents a false start during a break or while the line is held low.
  - Any other encoding goes to RESET.
- Timing: let t0 be the cycle rx_s is first seen low in IDLE.
  - Sample n (n = 0 start, 1..8 data, 9 stop) is taken at t0 + OVERSAMPLE/2 + n*OVERSAMPLE.
  - done and out update on the edge after the stop sample: t0 + 9.5*OVERSAMPLE + 1 (t0 + 153 for 16x).
  - done is high for exactly 1 cycle. Raw pin to rx_s adds SYNC_STAGES cycles.
- Back-to-back frames: IDLE is re-entered in the cycle after the stop sample. A start edge arriving half a bit after the stop-bit centre is caught, so frames with one stop bit at full rate are received without loss.
- en low (synchronous, any state):
  - Next state = RESET; busy = 0, done = 0.
  - out and err hold; a partially received frame is discarded.
- rst_n asserted mid-frame: all outputs and state go immediately to their reset values; no done.
- err semantics: err is valid while done = 1, holds until the next valid start sample, and is cleared there.

Test Plan:
- Frame 0xA5 at 16x, 1 stop: line bits 0,1,0,1,0,0,1,0,1,1 -> done pulses once at t0+153, out = 0xA5, err = 0, busy high t0..t0+152.
- 3-cycle low glitch on idle line -> START_BIT aborts at midpoint, no done, busy returns to 0, out unchanged.
- Frame 0x3C with stop bit = 0, line low for 20 bits, then high -> done once, out = 0x3C, err = 1; no second done until the line goes high and a new frame arrives.
- Back-to-back 0x00, 0xFF, 0x55, 1 stop each -> three done pulses 160 cycles apart, out sequence 0x00, 0xFF, 0x55, err = 0.
- rst_n low at data bit 4 of 0x81, then release and send 0x42 -> no done for 0x81; out = 0x00 after reset, then 0x42.
- en low for 5 cycles mid-frame of 0x99, then send 0x7E -> no done for 0x99, out = 0x7E afterwards.
